// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request/response bundle plus the downstream bridge bus
interface bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_byteen;
  logic        m0_lock;
  logic        m0_gnt;
  logic        m0_done;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_byteen;
  logic        m1_lock;
  logic        m1_gnt;
  logic        m1_done;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_byteen;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_byteen, m0_lock,
    input  m1_req, m1_addr, m1_wdata, m1_byteen, m1_lock,
    input  s_rdata,
    output m0_gnt, m0_done, m0_err, m0_rdata,
    output m1_gnt, m1_done, m1_err, m1_rdata,
    output s_addr, s_wdata, s_byteen
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_byteen, m0_lock,
    output m1_req, m1_addr, m1_wdata, m1_byteen, m1_lock,
    output s_rdata,
    input  m0_gnt, m0_done, m0_err, m0_rdata,
    input  m1_gnt, m1_done, m1_err, m1_rdata,
    input  s_addr, s_wdata, s_byteen
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin/lock arbiter and 3-state transfer sequencer for two bus masters
module bus_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_t;

  state_t        state;
  state_t        state_nx;
  logic          owner;
  logic          rr_last;
  logic [CW-1:0] lock_cnt;
  logic          lat_lock;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_byteen;
  logic          win;
  logic          win_lock;
  logic          mapped;
  logic          busy;

  function automatic logic addr_mapped(input logic [31:0] a);
    return (a <= 32'h0000_2fff) ||
           (a >= 32'h0000_7f00 && a <= 32'h0000_7f0b) ||
           (a >= 32'h0000_7f10 && a <= 32'h0000_7f1b) ||
           (a >= 32'h0000_7f20 && a <= 32'h0000_7f23);
  endfunction

  always_comb begin
    state_nx = state;
    win      = owner;
    win_lock = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_nx = ADDR;
          if (bus.m0_req && bus.m1_req) begin
            // lat_lock still holds the lock flag of the transfer that just finished
            if (lat_lock && lock_cnt < LOCK_MAX) begin
              win      = owner;
              win_lock = 1'b1;
            end else begin
              win = !rr_last;
            end
          end else begin
            win = bus.m1_req;
          end
        end
      end
      ADDR:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_last    <= 1'b1;
      lock_cnt   <= '0;
      lat_lock   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_byteen <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == ADDR) begin
        owner      <= win;
        rr_last    <= win;
        lock_cnt   <= win_lock ? lock_cnt + CW'(1) : '0;
        lat_lock   <= win ? bus.m1_lock   : bus.m0_lock;
        lat_addr   <= win ? bus.m1_addr   : bus.m0_addr;
        lat_wdata  <= win ? bus.m1_wdata  : bus.m0_wdata;
        lat_byteen <= win ? bus.m1_byteen : bus.m0_byteen;
      end
    end
  end

  assign mapped = addr_mapped(lat_addr);
  assign busy   = (state == ADDR) || (state == RESP);

  assign bus.s_addr   = lat_addr;
  assign bus.s_wdata  = lat_wdata;
  assign bus.s_byteen = (state == ADDR && mapped) ? lat_byteen : 4'b0000;

  assign bus.m0_gnt   = busy && !owner;
  assign bus.m1_gnt   = busy && owner;
  assign bus.m0_done  = (state == RESP) && !owner;
  assign bus.m1_done  = (state == RESP) && owner;
  assign bus.m0_err   = bus.m0_done && !mapped;
  assign bus.m1_err   = bus.m1_done && !mapped;
  assign bus.m0_rdata = (bus.m0_done && mapped) ? bus.s_rdata : 32'h0;
  assign bus.m1_rdata = (bus.m1_done && mapped) ? bus.s_rdata : 32'h0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed checks of bus_arbiter against a transaction model
module tb_bus_arbiter;
  localparam int MAX_LOCK = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;
  bit   chk_en;

  bus_arbiter_if bif ();

  bus_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [8192];
  logic [31:0] exp_mem [8192];

  function automatic int idx(input logic [31:0] a);
    return int'(a[14:2]);
  endfunction

  function automatic bit in_map(input logic [31:0] a);
    if (a < 32'h3000) return 1'b1;
    if (a >= 32'h7f00 && a < 32'h7f0c) return 1'b1;
    if (a >= 32'h7f10 && a < 32'h7f1c) return 1'b1;
    if (a >= 32'h7f20 && a < 32'h7f24) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // bridge: registered read of the presented address, byte-enabled writes
  always @(posedge clk) begin
    bif.s_rdata <= mem[idx(bif.s_addr)];
    for (int b = 0; b < 4; b++)
      if (bif.s_byteen[b]) mem[idx(bif.s_addr)][8*b +: 8] = bif.s_wdata[8*b +: 8];
  end

  typedef struct packed {
    logic        who;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        lock;
  } xfer_t;

  int          phase;
  xfer_t       cur;
  int          prev_owner;
  logic        prev_lock;
  int          streak;
  int          last_rr;
  logic [31:0] resp_rdata;
  logic [1:0]  e_gnt, e_done, e_err;
  logic [31:0] e_rdata [2];
  logic [3:0]  e_sbe;

  // transaction-level reference: phase counts cycles since a grant
  always @(posedge clk) begin
    int w;
    cyc++;
    if (phase == 1) begin
      resp_rdata = in_map(cur.addr) ? exp_mem[idx(cur.addr)] : 32'h0;
      if (in_map(cur.addr))
        for (int b = 0; b < 4; b++)
          if (cur.be[b]) exp_mem[idx(cur.addr)][8*b +: 8] = cur.wdata[8*b +: 8];
    end
    if (!reset) begin
      phase = 0; cur = '0; prev_owner = 0; prev_lock = 1'b0; streak = 0; last_rr = 1;
      chk_en = 1'b1;
    end else if (phase == 0) begin
      if (bif.m0_req || bif.m1_req) begin
        if (bif.m0_req && bif.m1_req) begin
          if (prev_lock && streak < MAX_LOCK) begin
            w = prev_owner; streak++;
          end else begin
            w = 1 - last_rr; streak = 0;
          end
        end else begin
          w = bif.m1_req ? 1 : 0; streak = 0;
        end
        if (w == 1) cur = {1'b1, bif.m1_addr, bif.m1_wdata, bif.m1_byteen, bif.m1_lock};
        else        cur = {1'b0, bif.m0_addr, bif.m0_wdata, bif.m0_byteen, bif.m0_lock};
        prev_owner = w; prev_lock = cur.lock; last_rr = w; phase = 1;
      end
    end else begin
      phase = (phase == 2) ? 0 : phase + 1;
    end
    e_gnt = '0; e_done = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    e_sbe = (phase == 1 && in_map(cur.addr)) ? cur.be : 4'h0;
    if (phase != 0) e_gnt[cur.who] = 1'b1;
    if (phase == 2) begin
      e_done[cur.who]  = 1'b1;
      e_err[cur.who]   = !in_map(cur.addr);
      e_rdata[cur.who] = in_map(cur.addr) ? resp_rdata : 32'h0;
    end
  end

  int glog_who[$];
  int glog_cyc[$];
  bit prev_any;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m0_gnt",   32'(bif.m0_gnt),   32'(e_gnt[0]));
      chk("m0_done",  32'(bif.m0_done),  32'(e_done[0]));
      chk("m0_err",   32'(bif.m0_err),   32'(e_err[0]));
      chk("m0_rdata", bif.m0_rdata,      e_rdata[0]);
      chk("m1_gnt",   32'(bif.m1_gnt),   32'(e_gnt[1]));
      chk("m1_done",  32'(bif.m1_done),  32'(e_done[1]));
      chk("m1_err",   32'(bif.m1_err),   32'(e_err[1]));
      chk("m1_rdata", bif.m1_rdata,      e_rdata[1]);
      chk("s_addr",   bif.s_addr,        cur.addr);
      chk("s_wdata",  bif.s_wdata,       cur.wdata);
      chk("s_byteen", 32'(bif.s_byteen), 32'(e_sbe));
    end
    if ((bif.m0_gnt || bif.m1_gnt) && !prev_any) begin
      glog_who.push_back(bif.m1_gnt ? 1 : 0);
      glog_cyc.push_back(cyc);
    end
    prev_any = bif.m0_gnt || bif.m1_gnt;
  end

  task automatic drive(input int m, input logic req, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input logic lk);
    if (m == 0) begin
      bif.m0_req = req; bif.m0_addr = a; bif.m0_wdata = wd; bif.m0_byteen = be; bif.m0_lock = lk;
    end else begin
      bif.m1_req = req; bif.m1_addr = a; bif.m1_wdata = wd; bif.m1_byteen = be; bif.m1_lock = lk;
    end
  endtask

  function automatic logic get_done(input int m);
    return (m != 0) ? bif.m1_done : bif.m0_done;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 32'($urandom_range(0, 32'hbff)) << 2;
      4:          return 32'h7f00 + 4 * $urandom_range(0, 2);
      5:          return 32'h7f10 + 4 * $urandom_range(0, 2);
      6:          return 32'h7f20;
      7:          return 32'h3000 + 4 * $urandom_range(0, 3);
      8:          return 32'h7f0c + 32'h10 * $urandom_range(0, 1);
      default:    return $urandom_range(0, 1) ? 32'h7f24 : 32'h7efc;
    endcase
  endfunction

  // call and return at negedge+1; lock_mode 0 never, 1 always, 2 random
  task automatic run_master(input int m, input int n, input int max_gap, input int lock_mode);
    for (int i = 0; i < n; i++) begin
      bit got;
      logic [3:0] be;
      logic lk;
      repeat ($urandom_range(0, max_gap)) begin @(negedge clk); #1; end
      be = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      lk = (lock_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(lock_mode);
      drive(m, 1'b1, rand_addr(), $urandom, be, lk);
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (get_done(m)) got = 1'b1;
      end
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL m%0d_done_timeout: got no done, expected done within 60 cycles", m);
      end
      #1;
      drive(m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    end
  endtask

  task automatic one_xfer(input int m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [3:0] exp_be, input logic exp_err,
                          input bit chk_rd, input logic [31:0] exp_rd);
    drive(m, 1'b1, a, wd, be, 1'b0);
    @(negedge clk);
    chk("x_addr_gnt",   32'((m != 0) ? bif.m1_gnt : bif.m0_gnt), 32'h1);
    chk("x_addr_be",    32'(bif.s_byteen), 32'(exp_be));
    chk("x_addr_done",  32'(get_done(m)), 32'h0);
    @(negedge clk);
    chk("x_resp_done",  32'(get_done(m)), 32'h1);
    chk("x_resp_be",    32'(bif.s_byteen), 32'h0);
    chk("x_resp_err",   32'((m != 0) ? bif.m1_err : bif.m0_err), 32'(exp_err));
    if (chk_rd) chk("x_resp_rdata", (m != 0) ? bif.m1_rdata : bif.m0_rdata, exp_rd);
    #1;
    drive(m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("x_idle_gnt",   32'(bif.m0_gnt | bif.m1_gnt), 32'h0);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[idx(a)] = v;
    exp_mem[idx(a)] = v;
  endtask

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: got no end of test, expected finish before 400000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int exp_lock[8];
    tests = 0; fails = 0; cyc = 0; chk_en = 1'b0; prev_any = 1'b0; phase = 0;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 32'(i) * 32'h9e37_79b1 + 32'h1;
      exp_mem[i] = mem[i];
    end
    preload(32'h0010, 32'h1234_5678);
    preload(32'h2ffc, 32'hc0ff_ee01);
    preload(32'h7f20, 32'h0000_00a5);
    preload(32'h3000, 32'hdead_beef);
    reset = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    @(negedge clk);
    chk("rst_gnt",   32'({bif.m0_gnt, bif.m1_gnt}), 32'h0);
    chk("rst_done",  32'({bif.m0_done, bif.m1_done, bif.m0_err, bif.m1_err}), 32'h0);
    chk("rst_saddr", bif.s_addr, 32'h0);
    chk("rst_sbe",   32'(bif.s_byteen), 32'h0);
    #1;
    reset = 1'b1;

    one_xfer(0, 32'h0010, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678);
    one_xfer(1, 32'h7f04, 32'haaaa_0005, 4'hf, 4'hf, 1'b0, 1'b0, 32'h0);
    one_xfer(0, 32'h7f04, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'haaaa_0005);
    one_xfer(0, 32'h3000, 32'h55, 4'hf, 4'h0, 1'b1, 1'b1, 32'h0);
    one_xfer(1, 32'h2ffc, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'hc0ff_ee01);
    one_xfer(1, 32'h7f0c, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1, 32'h0);
    one_xfer(0, 32'h7f20, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h0000_00a5);
    one_xfer(1, 32'h7f24, 32'h77, 4'h3, 4'h0, 1'b1, 1'b1, 32'h0);

    // continuous contention without lock must alternate every 3 cycles
    do_reset();
    glog_who.delete(); glog_cyc.delete();
    fork
      run_master(0, 4, 0, 0);
      run_master(1, 4, 0, 0);
    join
    chk("tie_count", 32'(glog_who.size()), 32'd8);
    for (int i = 0; i < glog_who.size() && i < 8; i++) begin
      chk("tie_owner", 32'(glog_who[i]), 32'(i % 2));
      if (i > 0) chk("tie_spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd3);
    end

    do_reset();
    glog_who.delete(); glog_cyc.delete();
    fork
      run_master(0, 6, 0, 1);
      run_master(1, 2, 0, 0);
    join
    exp_lock = '{0, 0, 0, 0, 0, 1, 0, 1};
    chk("lock_count", 32'(glog_who.size()), 32'd8);
    for (int i = 0; i < glog_who.size() && i < 8; i++)
      chk("lock_owner", 32'(glog_who[i]), 32'(exp_lock[i]));

    // reset while in RESP, then tie after release goes to M0
    do_reset();
    drive(0, 1'b1, 32'h0010, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_resp_done", 32'(bif.m0_done), 32'h1);
    #1;
    reset = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("rr_after_gnt",  32'({bif.m0_gnt, bif.m1_gnt}), 32'h0);
    chk("rr_after_done", 32'({bif.m0_done, bif.m1_done}), 32'h0);
    chk("rr_after_addr", bif.s_addr, 32'h0);
    #1;
    reset = 1'b1;
    drive(0, 1'b1, 32'h0020, 32'h0, 4'h0, 1'b0);
    drive(1, 1'b1, 32'h0024, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("rr_first_m0", 32'(bif.m0_gnt), 32'h1);
    chk("rr_first_m1", 32'(bif.m1_gnt), 32'h0);
    @(negedge clk);
    #1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    run_master(1, 0, 0, 0);
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (bif.m1_done) got = 1'b1;
      end
      chk("rr_m1_served", 32'(got), 32'h1);
      #1;
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    end

    // reset landing in ADDR: the write issued that cycle stands, no done
    @(negedge clk); #1;
    drive(1, 1'b1, 32'h0100, 32'h5a5a_5a5a, 4'hf, 1'b0);
    @(negedge clk);
    chk("ra_addr_be", 32'(bif.s_byteen), 32'hf);
    #1;
    reset = 1'b0;
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("ra_no_done", 32'({bif.m0_done, bif.m1_done}), 32'h0);
    #1;
    reset = 1'b1;
    one_xfer(0, 32'h0100, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h5a5a_5a5a);

    fork
      run_master(0, 40, 3, 2);
      run_master(1, 40, 3, 2);
    join
    fork
      run_master(0, 30, 0, 2);
      run_master(1, 30, 1, 1);
    join
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
